// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: PC, two byte reads, big-endian opcode, valid/ready out.
// Optional CHIP8_FETCH_BOUNDS_CHECK_EN faults instead of wrapping the low-byte read.
module chip8_fetch #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = 'h200
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_q,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [15:0]           opcode,
  output logic [ADDR_WIDTH-1:0] op_pc,
  input  logic                  jmp,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  input  logic                  skip,
  output logic                  fault
);

  localparam logic [2:0] RD_HI = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] CAPT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
  localparam logic [2:0] FAULT = 3'd4;
`endif

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_p1;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [7:0]            hi;
  logic                  bound_hit;

  assign pc_p1 = pc + ADDR_WIDTH'(1);

`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
  // Last address: the low-byte read would wrap to zero.
  assign bound_hit = (pc == {ADDR_WIDTH{1'b1}});
`else
  assign bound_hit = 1'b0;
`endif

  always_comb begin
    pc_next = pc + ADDR_WIDTH'(2);
    if (jmp)
      pc_next = jmp_addr;
    else if (skip)
      pc_next = pc + ADDR_WIDTH'(4);
  end

  always_comb begin
    mem_re    = 1'b0;
    mem_raddr = '0;
    unique case (1'b1)
      (state == RD_HI): begin
        if (!bound_hit) begin
          mem_re    = 1'b1;
          mem_raddr = pc;
        end
      end
      (state == RD_LO): begin
        mem_re    = 1'b1;
        mem_raddr = pc_p1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RD_HI;
      pc       <= PC_RESET;
      hi       <= '0;
      opcode   <= '0;
      op_pc    <= '0;
      op_valid <= 1'b0;
    end else begin
      unique case (state)
        RD_HI: begin
`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
          if (bound_hit)
            state <= FAULT;
          else
            state <= RD_LO;
`else
          state <= RD_LO;
`endif
        end
        RD_LO: begin
          hi    <= mem_q;
          state <= CAPT;
        end
        CAPT: begin
          opcode   <= {hi, mem_q};
          op_pc    <= pc;
          op_valid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (op_ready) begin
            pc       <= pc_next;
            op_valid <= 1'b0;
            state    <= RD_HI;
          end
        end
        default: begin
`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
          state <= FAULT;
`else
          state <= RD_HI;
`endif
        end
      endcase
    end
  end

`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault <= 1'b0;
    else if (state == RD_HI && bound_hit)
      fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_fetch.sv
// Bench for chip8_fetch: byte memory model plus expected-opcode scoreboard.
// Scenarios cover reset, stalls, skip/jmp, wrap, mid-fetch reset and bounds.
module tb_chip8_fetch;

  typedef struct {
    logic [11:0] pc;
    logic [15:0] op;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_re;
  logic [11:0] mem_raddr;
  logic [7:0]  mem_q = 8'h00;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [15:0] opcode;
  logic [11:0] op_pc;
  logic        jmp = 1'b0;
  logic [11:0] jmp_addr = 12'h000;
  logic        skip = 1'b0;
  logic        fault;

  logic [7:0]  mem [4096];
  exp_t        sbq [$];
  int          n_vec = 0;
  int          n_bad = 0;

  chip8_fetch #(.ADDR_WIDTH(12), .PC_RESET(12'h200)) dut (
    .clk(clk), .rst(rst),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_q(mem_q),
    .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .op_pc(op_pc),
    .jmp(jmp), .jmp_addr(jmp_addr), .skip(skip),
    .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_re) mem_q <= mem[mem_raddr];

  function automatic exp_t mk(input logic [11:0] pc);
    exp_t e;
    logic [11:0] p1;
    p1 = pc + 12'd1;
    e.pc = pc;
    e.op = {mem[pc], mem[p1]};
    return e;
  endfunction

  // Caller is positioned at a negedge with the DUT in RD_HI.
  task automatic fetch_one(input int hold, input logic j, input logic s,
                           input logic [11:0] ja);
    logic [11:0] addrs [$];
    logic [11:0] nxt;
    logic [11:0] p1;
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (op_valid) begin
        got = 1;
        break;
      end
      if (mem_re) addrs.push_back(mem_raddr);
      lat++;
      @(negedge clk);
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL timeout op_valid got 0 want 1");
      return;
    end
    if (sbq.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard empty got opcode %h", opcode);
      return;
    end
    e = sbq.pop_front();
    p1 = e.pc + 12'd1;
    n_vec++;
    if (opcode !== e.op) begin
      n_bad++;
      $display("FAIL opcode got %h want %h", opcode, e.op);
    end
    n_vec++;
    if (op_pc !== e.pc) begin
      n_bad++;
      $display("FAIL op_pc got %h want %h", op_pc, e.pc);
    end
    n_vec++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL latency got %0d want 3", lat);
    end
    n_vec++;
    if (addrs.size() != 2 || addrs[0] !== e.pc || addrs[1] !== p1) begin
      n_bad++;
      $display("FAIL raddr_seq got n=%0d %h %h want %h %h", addrs.size(),
               addrs.size() > 0 ? addrs[0] : 12'hxxx,
               addrs.size() > 1 ? addrs[1] : 12'hxxx, e.pc, p1);
    end
    for (int h = 0; h < hold; h++) begin
      op_ready = 1'b0;
      jmp      = 1'b1;
      skip     = 1'b1;
      jmp_addr = 12'($urandom);
      n_vec++;
      if (!op_valid || opcode !== e.op || op_pc !== e.pc ||
          mem_re !== 1'b0 || mem_raddr !== 12'h000) begin
        n_bad++;
        $display("FAIL hold got v=%b op=%h pc=%h re=%b a=%h want v=1 op=%h pc=%h re=0 a=000",
                 op_valid, opcode, op_pc, mem_re, mem_raddr, e.op, e.pc);
      end
      @(negedge clk);
    end
    op_ready = 1'b1;
    jmp      = j;
    skip     = s;
    jmp_addr = ja;
    if (j)      nxt = ja;
    else if (s) nxt = e.pc + 12'd4;
    else        nxt = e.pc + 12'd2;
    sbq.push_back(mk(nxt));
    @(negedge clk);
    op_ready = 1'b0;
    jmp      = 1'b0;
    skip     = 1'b0;
    n_vec++;
    if (op_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake op_valid got %b want 0", op_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (op_valid !== 1'b0 || opcode !== 16'h0000 || op_pc !== 12'h000 ||
        fault !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_regs got v=%b op=%h pc=%h f=%b want 0 0000 000 0",
               op_valid, opcode, op_pc, fault);
    end
    n_vec++;
    if (mem_re !== 1'b1 || mem_raddr !== 12'h200) begin
      n_bad++;
      $display("FAIL reset_read got re=%b a=%h want re=1 a=200", mem_re, mem_raddr);
    end
    rst = 1'b0;
    sbq.delete();
    sbq.push_back(mk(12'h200));
  endtask

  task automatic test_basic;
    fetch_one(0, 1'b0, 1'b0, 12'h000);
    fetch_one(10, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic test_skip_jmp;
    fetch_one(0, 1'b0, 1'b1, 12'h000);
    fetch_one(0, 1'b1, 1'b1, 12'h300);
    fetch_one(0, 1'b1, 1'b0, 12'hFFE);
  endtask

  task automatic test_wrap;
    fetch_one(0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 6; k++)
      fetch_one($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 12'($urandom_range(12'h200, 12'hEFF)));
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (op_valid !== 1'b0 || mem_re !== 1'b1 || mem_raddr !== 12'h200 ||
        opcode !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_mid got v=%b re=%b a=%h op=%h want 0 1 200 0000",
               op_valid, mem_re, mem_raddr, opcode);
    end
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    sbq.push_back(mk(12'h200));
    fetch_one(0, 1'b1, 1'b0, 12'hFFF);
  endtask

  task automatic test_bounds;
`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
    n_vec++;
    if (mem_re !== 1'b0 || mem_raddr !== 12'h000 || op_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bound_rd got re=%b a=%h v=%b want 0 000 0",
               mem_re, mem_raddr, op_valid);
    end
    op_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vec++;
      if (fault !== 1'b1 || mem_re !== 1'b0 || op_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fault_hold got f=%b re=%b v=%b want 1 0 0",
                 fault, mem_re, op_valid);
      end
    end
    op_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    sbq.push_back(mk(12'h200));
    fetch_one(0, 1'b0, 1'b0, 12'h000);
`else
    fetch_one(0, 1'b0, 1'b0, 12'h000);
`endif
    n_vec++;
    if (fault !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_clear got %b want 0", fault);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h200] = 8'h12;
    mem[12'h201] = 8'h34;
    mem[12'hFFE] = 8'hA1;
    mem[12'hFFF] = 8'h23;
    test_reset;
    test_basic;
    test_skip_jmp;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    test_bounds;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
